// File: rtl/deco_sel_bbm_pkg.sv
// Shared types and helpers for the break-before-make select decoder.
package deco_sel_pkg;

  // Largest supported dead time; the counter is sized from the actual value.
  localparam int DEAD_CYCLES_MAX = 255;

  // Widest one-hot vector the helper can build (SEL_W up to 8).
  localparam int OH_MAX = 256;

  typedef enum logic {
    IDLE  = 1'b0,
    BREAK = 1'b1
  } deco_state_e;

  // One-hot of idx within an n-wide field. Callers cast the result down to their width.
  function automatic logic [OH_MAX-1:0] onehot(input logic [7:0] idx, input int unsigned n);
    logic [OH_MAX-1:0] r;
    r = '0;
    if (32'(idx) < n) r = {{(OH_MAX-1){1'b0}}, 1'b1} << idx;
    return r;
  endfunction

endpackage

// File: rtl/deco_sel_bbm_if.sv
// Control/status bundle between the sequencing logic and the select decoder.
// The overrun status line exists only when DECO_SEL_OVERRUN_ERR_EN is defined.
interface deco_sel_bbm_if #(
  parameter int SEL_W = 2
);
  localparam int N_OUT = 2 ** SEL_W;

  logic             enable;
  logic             load;
  logic [SEL_W-1:0] binary_in;
  logic [N_OUT-1:0] decoder_out;
  logic             busy;
  logic             done;
`ifdef DECO_SEL_OVERRUN_ERR_EN
  logic             overrun;

  modport master (output enable, load, binary_in, input decoder_out, busy, done, overrun);
  modport slave  (input enable, load, binary_in, output decoder_out, busy, done, overrun);
`else
  modport master (output enable, load, binary_in, input decoder_out, busy, done);
  modport slave  (input enable, load, binary_in, output decoder_out, busy, done);
`endif

endinterface

// File: rtl/deco_sel_bbm_deadtimer.sv
// Loadable down-counter that times the all-zero gap on a channel change.
// expire is high whenever the count has reached zero.
module deco_sel_deadtimer #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;

  // Load on start, otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/deco_sel_bbm.sv
// Registered binary-to-one-hot select decoder with break-before-make switching.
// Optional build macro: DECO_SEL_OVERRUN_ERR_EN adds the overrun status pulse.
//
// state | meaning
// IDLE  | outputs stable, waiting for a load
// BREAK | outputs held at zero while the dead timer runs
module deco_sel_bbm
  import deco_sel_pkg::*;
#(
  parameter int SEL_W       = 2,
  parameter int DEAD_CYCLES = 2
) (
  input logic           clk,
  input logic           reset,
  deco_sel_bbm_if.slave bus
);

  localparam int N_OUT = 2 ** SEL_W;
  localparam int CNT_W = (DEAD_CYCLES < 2) ? 1 : $clog2(DEAD_CYCLES + 1);
  // The timer expires on its load value's last edge, so load one less than the gap.
  localparam logic [CNT_W-1:0] DEAD_LOAD = (DEAD_CYCLES > 0) ? CNT_W'(DEAD_CYCLES - 1) : '0;

  deco_state_e      state_q, state_d;
  logic [N_OUT-1:0] out_q, out_d;
  logic [SEL_W-1:0] target_q, target_d;
  logic             active_q, active_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic             tmr_start;
  logic             tmr_expire;

  deco_sel_deadtimer #(.CNT_W(CNT_W)) u_deadtimer (
    .clk      (clk),
    .reset    (reset),
    .start    (tmr_start),
    .load_val (DEAD_LOAD),
    .expire   (tmr_expire)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      out_q    <= '0;
      target_q <= '0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      target_q <= target_d;
      active_q <= active_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  // Next-state and next-output decision.
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    target_d  = target_q;
    active_d  = active_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovr_d     = 1'b0;
    tmr_start = 1'b0;

    if (!bus.enable) begin
      state_d  = IDLE;
      out_d    = '0;
      busy_d   = 1'b0;
      active_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.load) begin
            target_d = bus.binary_in;
            if (active_q && (bus.binary_in == target_q)) begin
              done_d = 1'b1;
            end else if (!active_q || (DEAD_CYCLES == 0)) begin
              out_d    = N_OUT'(onehot(8'(bus.binary_in), N_OUT));
              active_d = 1'b1;
              done_d   = 1'b1;
            end else begin
              out_d     = '0;
              active_d  = 1'b0;
              busy_d    = 1'b1;
              tmr_start = 1'b1;
              state_d   = BREAK;
            end
          end
        end
        BREAK: begin
          // A late request simply retargets; the gap already elapsed still counts.
          if (bus.load) target_d = bus.binary_in;
          ovr_d = bus.load;
          if (tmr_expire) begin
            out_d    = N_OUT'(onehot(8'(target_d), N_OUT));
            active_d = 1'b1;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.decoder_out = out_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
`ifdef DECO_SEL_OVERRUN_ERR_EN
  assign bus.overrun     = ovr_q;
`endif

endmodule
